bus_seq_ctrl: RTL
=================

Name: bus_seq_ctrl

Overview:
- Control sequencer for the single shared 32-bit CPU bus.
- Each cycle it drives the one-hot source-select vector that feeds the bus encoder/mux, plus register load enables and ALU/memory controls.
- Executes fetch, then execute, for reg-reg ALU, immediate ALU, MUL and DIV instructions.
- Guarantees at most one bus driver per cycle.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles spent in T1 waiting for mem_ready before aborting with err.
- OPC_W, 5: opcode field width, ir[31:27].

Ports:
- clk  in  1  system clock; all state updates on rising edge
- clear_n  in  1  asynchronous active-low reset
- start  in  1  begin one instruction cycle; sampled only in IDLE
- ir  in  32  IR contents; valid from T3 onward; ra=ir[26:23], rb=ir[22:19], rc=ir[18:15]
- mem_ready  in  1  memory read data valid on MDR input
- src_out  out  24  one-hot bus source select; bits 0-15 r0-r15, 16 HI, 17 LO, 18 ZHI, 19 ZLOW, 20 PC, 21 MDR, 22 inPort, 23 C
- reg_in  out  16  one-hot general register load
- pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in  out  1 each  register load enables
- inc_pc  out  1  ALU computes bus+1 in T0
- mem_read  out  1  memory read request
- alu_op  out  5  opcode passed to ALU; 0 when idle
- busy  out  1  high from T0 through last T-state
- done  out  1  one-cycle pulse on instruction completion
- err  out  1  one-cycle pulse on illegal opcode or memory timeout

Behaviour:
- Reset (async, clear_n=0): state=IDLE, wait counter=0, every output 0. Applies immediately, including mid-instruction; no partial write-back.
- All outputs are Moore-decoded from registered state and the latched opcode/fields. No combinational path from start to outputs.
- IDLE: start=1 moves to T0 next cycle. start is ignored in all other states.
- T0: src_out[20] (PC), mar_in, inc_pc, z_in.
- T1: src_out[19] (ZLOW), pc_in, mem_read. mdr_in=mem_ready.
  - Stay in T1 while mem_ready=0; the counter increments each stalled cycle.
  - mem_ready=1 moves to T2 and clears the counter.
  - Counter reaching MEM_WAIT_MAX with mem_ready=0: err pulse, go to IDLE. PC has already been incremented.
- T2: src_out[21] (MDR), ir_in.
- T3: latch opcode/ra/rb/rc from ir. src_out[rb], y_in.
  - Legal opcodes: 0x03-0x0B reg-reg, 0x0C-0x0E immediate, 0x0F MUL, 0x10 DIV.
  - Any other opcode: err pulse in T3 with y_in suppressed and no bus drive, then IDLE.
- T4: alu_op=opcode, z_in. Operand source: src_out[rc] for reg-reg/MUL/DIV; src_out[23] (C) for immediate.
- T5, ALU classes: src_out[19], reg_in[ra], done pulse, then IDLE.
- T5, MUL/DIV: src_out[19], lo_in.
- T6, MUL/DIV only: src_out[18] (ZHI), hi_in, done pulse, then IDLE.
- One-hot invariant: popcount(src_out)<=1 and popcount(reg_in)<=1 every cycle. src_out=0 in IDLE.
- busy=1 in T0-T6 and during T1 stall; 0 in IDLE.
- done and err are never asserted in the same cycle.
- Back-to-back: start held high in the completing cycle is not seen. The next T0 begins at the earliest on the cycle after IDLE is re-entered with start=1.
- ra=rb=rc is legal with no special handling. Writes to r0 are permitted; zero-register semantics, if any, live in the register file.

Decomposition:
- Shared package bus_ctrl_pkg: state enum (IDLE,T0..T6); src index constants (SRC_R0=0 … SRC_C=23); opcode constants and class ranges.
- One sub-module: bus_seq_decode, a combinational state+class to control-vector decoder.
- The state register, wait counter and field latches stay in bus_seq_ctrl.

Test Plan:
- Reset: clear_n=0 asserted mid-T4 → all outputs 0 in the same cycle, state IDLE. Release, start=1 → T0 with src_out=0x100000, mar_in=1.
- ADD (opcode 0x03, ra=2, rb=4, rc=5), mem_ready=1 in first T1 cycle → src_out per cycle T0-T5 = 0x100000, 0x080000, 0x200000, 0x000010, 0x000020, 0x080000; reg_in=0x0004 in T5; done in T5; total 6 cycles.
- ADDI (0x0C, ra=1, rb=3) → T4 src_out=0x800000, alu_op=0x0C; T5 reg_in=0x0002.
- MUL (0x0F, rb=6, rc=7) → T5 lo_in with src_out=0x080000; T6 hi_in with src_out=0x040000; done only in T6; 7 cycles.
- mem_ready delayed 3 cycles → T1 held 4 cycles, mem_read high throughout, mdr_in only in the last. Separately, mem_ready never asserted → err after 15 stall cycles, then IDLE, done never seen.
- Illegal opcode 0x1F → err in T3, no reg_in/y_in asserted. Random legal streams with assertion checks: one-hot src_out/reg_in every cycle, start ignored while busy.

Source files
------------

// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the shared-bus control sequencer.
//   - state_e     : sequencer state (IDLE, then T-states T0..T6)
//   - SRC_*       : bit positions in the one-hot bus source-select vector
//   - OPC_*       : opcode values and class boundaries
//   - opc_class_e : instruction class used to steer T3..T6
//   - ctrl_t      : complete per-cycle control vector from the decoder
package bus_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_T6   = 3'd7
    } state_e;

    localparam int SRC_W      = 24;
    localparam int NUM_REGS   = 16;
    localparam int SRC_R0     = 0;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLOW   = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_C      = 23;

    localparam logic [4:0] OPC_ALU_FIRST = 5'h03;
    localparam logic [4:0] OPC_ALU_LAST  = 5'h0B;
    localparam logic [4:0] OPC_IMM_FIRST = 5'h0C;
    localparam logic [4:0] OPC_IMM_LAST  = 5'h0E;
    localparam logic [4:0] OPC_MUL       = 5'h0F;
    localparam logic [4:0] OPC_DIV       = 5'h10;

    typedef enum logic [1:0] {
        CLS_ILLEGAL = 2'd0,
        CLS_ALU     = 2'd1,
        CLS_IMM     = 2'd2,
        CLS_MULDIV  = 2'd3
    } opc_class_e;

    function automatic opc_class_e classify(input logic [4:0] opc);
        opc_class_e cls;
        cls = CLS_ILLEGAL;
        if (opc >= OPC_ALU_FIRST && opc <= OPC_ALU_LAST)
            cls = CLS_ALU;
        else if (opc >= OPC_IMM_FIRST && opc <= OPC_IMM_LAST)
            cls = CLS_IMM;
        else if (opc == OPC_MUL || opc == OPC_DIV)
            cls = CLS_MULDIV;
        return cls;
    endfunction

    typedef struct packed {
        logic [SRC_W-1:0]    src_out;
        logic [NUM_REGS-1:0] reg_in;
        logic                pc_in;
        logic                ir_in;
        logic                mar_in;
        logic                mdr_in;
        logic                y_in;
        logic                z_in;
        logic                hi_in;
        logic                lo_in;
        logic                inc_pc;
        logic                mem_read;
        logic [4:0]          alu_op;
        logic                busy;
        logic                done;
        logic                err;
    } ctrl_t;

endpackage

// File: rtl/bus_seq_decode.sv
// Combinational decoder: sequencer state + instruction class -> control vector.
// Ports:
//   state        current sequencer state
//   cls          instruction class (live from IR in T3, latched afterwards)
//   ra, rb, rc   register fields (rb live from IR in T3; ra/rc latched)
//   opc          latched opcode, presented to the ALU in T4
//   mem_ready    memory read data valid
//   wait_expired T1 wait counter is on its last allowed stall cycle
//   ctrl         full control vector for this cycle
// Each state sets at most one src_out bit and at most one reg_in bit, so the
// bus never has two drivers.
module bus_seq_decode
    import bus_ctrl_pkg::*;
(
    input  state_e     state,
    input  opc_class_e cls,
    input  logic [3:0] ra,
    input  logic [3:0] rb,
    input  logic [3:0] rc,
    input  logic [4:0] opc,
    input  logic       mem_ready,
    input  logic       wait_expired,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_IDLE: ;
            S_T0: begin
                ctrl.busy            = 1'b1;
                ctrl.src_out[SRC_PC] = 1'b1;
                ctrl.mar_in          = 1'b1;
                ctrl.inc_pc          = 1'b1;
                ctrl.z_in            = 1'b1;
            end
            S_T1: begin
                ctrl.busy              = 1'b1;
                ctrl.src_out[SRC_ZLOW] = 1'b1;
                ctrl.pc_in             = 1'b1;
                ctrl.mem_read          = 1'b1;
                ctrl.mdr_in            = mem_ready;
                ctrl.err               = !mem_ready && wait_expired;
            end
            S_T2: begin
                ctrl.busy             = 1'b1;
                ctrl.src_out[SRC_MDR] = 1'b1;
                ctrl.ir_in            = 1'b1;
            end
            S_T3: begin
                ctrl.busy = 1'b1;
                // Illegal opcode: report and leave the bus undriven.
                if (cls == CLS_ILLEGAL) begin
                    ctrl.err = 1'b1;
                end else begin
                    ctrl.src_out[{1'b0, rb}] = 1'b1;
                    ctrl.y_in                = 1'b1;
                end
            end
            S_T4: begin
                ctrl.busy   = 1'b1;
                ctrl.alu_op = opc;
                ctrl.z_in   = 1'b1;
                if (cls == CLS_IMM)
                    ctrl.src_out[SRC_C] = 1'b1;
                else
                    ctrl.src_out[{1'b0, rc}] = 1'b1;
            end
            S_T5: begin
                ctrl.busy              = 1'b1;
                ctrl.src_out[SRC_ZLOW] = 1'b1;
                if (cls == CLS_MULDIV) begin
                    ctrl.lo_in = 1'b1;
                end else begin
                    ctrl.reg_in[ra] = 1'b1;
                    ctrl.done       = 1'b1;
                end
            end
            S_T6: begin
                ctrl.busy             = 1'b1;
                ctrl.src_out[SRC_ZHI] = 1'b1;
                ctrl.hi_in            = 1'b1;
                ctrl.done             = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bus_seq_ctrl.sv
// Control sequencer for the shared 32-bit CPU bus: fetch (T0..T2) followed by
// execute (T3..T6) for reg-reg ALU, immediate ALU, MUL and DIV instructions.
// Ports:
//   clk, clear_n          clock, asynchronous active-low reset
//   start                 begin an instruction (only looked at in IDLE)
//   ir                    IR contents, valid from T3 onward
//   mem_ready             memory read data valid
//   src_out[23:0]         one-hot bus source select
//   reg_in[15:0]          one-hot general register load
//   pc_in .. lo_in        register load enables
//   inc_pc, mem_read      ALU increment and memory read request
//   alu_op[4:0]           opcode to ALU in T4, 0 otherwise
//   busy, done, err       status; done/err are single-cycle pulses
//   dbg_state             current sequencer state, for observation
// Handshake: mem_read is held for the whole of T1; the cycle in which
// mem_ready is seen high loads MDR and advances to T2. After MEM_WAIT_MAX
// stalled T1 cycles the instruction is abandoned with an err pulse.
module bus_seq_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int OPC_W        = 5
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [23:0] src_out,
    output logic [15:0] reg_in,
    output logic        pc_in,
    output logic        ir_in,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        y_in,
    output logic        z_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic        inc_pc,
    output logic        mem_read,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        err,
    output state_e      dbg_state
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_expired;
    logic [OPC_W-1:0] opc_q;
    logic [3:0]       ra_q, rc_q;
    opc_class_e       cls_q;
    opc_class_e       ir_cls;
    opc_class_e       cur_cls;
    ctrl_t            ctrl;
    logic             unused_ir;

    assign ir_cls       = classify(ir[31 -: OPC_W]);
    // T3 decodes straight from IR (fields are latched at the end of T3).
    assign cur_cls      = (state == S_T3) ? ir_cls : cls_q;
    assign wait_expired = (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));
    assign unused_ir    = ^ir[14:0];

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_T0;
            S_T0:   state_nxt = S_T1;
            S_T1: begin
                if (mem_ready)
                    state_nxt = S_T2;
                else if (wait_expired)
                    state_nxt = S_IDLE;
            end
            S_T2:   state_nxt = S_T3;
            S_T3:   state_nxt = (ir_cls == CLS_ILLEGAL) ? S_IDLE : S_T4;
            S_T4:   state_nxt = S_T5;
            S_T5:   state_nxt = (cls_q == CLS_MULDIV) ? S_T6 : S_IDLE;
            S_T6:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counts stalled T1 cycles; cleared on any exit from the stall.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            wait_cnt <= '0;
        else if (state == S_T1 && !mem_ready && !wait_expired)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            opc_q <= '0;
            ra_q  <= '0;
            rc_q  <= '0;
            cls_q <= CLS_ILLEGAL;
        end else if (state == S_T3) begin
            opc_q <= ir[31 -: OPC_W];
            ra_q  <= ir[26:23];
            rc_q  <= ir[18:15];
            cls_q <= ir_cls;
        end
    end

    bus_seq_decode u_decode (
        .state        (state),
        .cls          (cur_cls),
        .ra           (ra_q),
        .rb           (ir[22:19]),
        .rc           (rc_q),
        .opc          (opc_q),
        .mem_ready    (mem_ready),
        .wait_expired (wait_expired),
        .ctrl         (ctrl)
    );

    assign src_out   = ctrl.src_out;
    assign reg_in    = ctrl.reg_in;
    assign pc_in     = ctrl.pc_in;
    assign ir_in     = ctrl.ir_in;
    assign mar_in    = ctrl.mar_in;
    assign mdr_in    = ctrl.mdr_in;
    assign y_in      = ctrl.y_in;
    assign z_in      = ctrl.z_in;
    assign hi_in     = ctrl.hi_in;
    assign lo_in     = ctrl.lo_in;
    assign inc_pc    = ctrl.inc_pc;
    assign mem_read  = ctrl.mem_read;
    assign alu_op    = ctrl.alu_op;
    assign busy      = ctrl.busy;
    assign done      = ctrl.done;
    assign err       = ctrl.err;
    assign dbg_state = state;

endmodule
